// File: rtl/empty_ptr_pool_if.sv
// Shared hash-table sizing and the empty-pointer-storage handshake between
// the insert/delete control logic (master) and the free-list pool (slave).
package hash_table;
    localparam int TABLE_ADDR_WIDTH = 8;
endpackage

interface empty_ptr_storage_if #(
    parameter int A_WIDTH = hash_table::TABLE_ADDR_WIDTH
);
    logic               srst;
    logic [A_WIDTH-1:0] add_empty_ptr;
    logic               add_empty_ptr_en;
    logic               next_empty_ptr_rd_ack;
    logic [A_WIDTH-1:0] next_empty_ptr;
    logic               next_empty_ptr_val;

    modport master (
        output srst,
        output add_empty_ptr,
        output add_empty_ptr_en,
        output next_empty_ptr_rd_ack,
        input  next_empty_ptr,
        input  next_empty_ptr_val
    );

    modport slave (
        input  srst,
        input  add_empty_ptr,
        input  add_empty_ptr_en,
        input  next_empty_ptr_rd_ack,
        output next_empty_ptr,
        output next_empty_ptr_val
    );
endinterface

// File: rtl/empty_ptr_pool.sv
// Free-list manager for hash-table data RAM addresses: fills itself with every
// address after reset, then serves them in FIFO order through a show-ahead head.
module empty_ptr_pool #(
    parameter int A_WIDTH = hash_table::TABLE_ADDR_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    empty_ptr_storage_if.slave ptr_if,
    output logic               init_done_o,
    output logic [A_WIDTH:0]   free_cnt_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    localparam int unsigned        DEPTH    = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0]   FULL_CNT = {1'b1, {A_WIDTH{1'b0}}};
    localparam logic [A_WIDTH:0]   ZERO_CNT = {(A_WIDTH+1){1'b0}};
    localparam logic [A_WIDTH:0]   ONE_CNT  = {{A_WIDTH{1'b0}}, 1'b1};
    localparam logic [A_WIDTH-1:0] ZERO_PTR = {A_WIDTH{1'b0}};
    localparam logic [A_WIDTH-1:0] ONE_PTR  = {{(A_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [A_WIDTH-1:0] LAST_IDX = {A_WIDTH{1'b1}};

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_r, state_nxt_s;
    logic [A_WIDTH-1:0] mem_r [DEPTH];
    logic [A_WIDTH-1:0] init_idx_r, wr_ptr_r, rd_ptr_r, head_r;
    logic [A_WIDTH:0]   count_r;
    logic               val_r, init_done_r, overflow_r, underflow_r;

    logic               pop_s, push_s, we_s, ovf_set_s, unf_set_s, init_last_s, bypass_s;
    logic [A_WIDTH-1:0] waddr_s, wdata_s, rd_ptr_nxt_s;
    logic [A_WIDTH:0]   count_nxt_s;

    assign init_last_s = (init_idx_r == LAST_IDX);

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        if (ptr_if.srst) begin
            state_nxt_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: state_nxt_s = init_last_s ? ST_RUN : ST_INIT;
                ST_RUN:  state_nxt_s = ST_RUN;
                default: state_nxt_s = ST_INIT;
            endcase
        end
    end

    // FSM outputs: RAM write port and push/pop/flag decisions
    always_comb begin
        pop_s     = 1'b0;
        push_s    = 1'b0;
        we_s      = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        waddr_s   = wr_ptr_r;
        wdata_s   = ptr_if.add_empty_ptr;
        if (ptr_if.srst) begin
            we_s = 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    we_s      = 1'b1;
                    waddr_s   = init_idx_r;
                    wdata_s   = init_idx_r;
                    ovf_set_s = ptr_if.add_empty_ptr_en;
                    unf_set_s = ptr_if.next_empty_ptr_rd_ack;
                end
                ST_RUN: begin
                    pop_s     = ptr_if.next_empty_ptr_rd_ack & val_r;
                    unf_set_s = ptr_if.next_empty_ptr_rd_ack & ~val_r;
                    // a same-cycle pop frees the slot, so a full pool still accepts
                    push_s    = ptr_if.add_empty_ptr_en & ((count_r != FULL_CNT) | pop_s);
                    ovf_set_s = ptr_if.add_empty_ptr_en & ~push_s;
                    we_s      = push_s;
                end
                default: begin
                    we_s = 1'b0;
                end
            endcase
        end
    end

    // Next count, read pointer and write-to-read bypass detection
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_CNT;
            2'b01:   count_nxt_s = count_r - ONE_CNT;
            default: count_nxt_s = count_r;
        endcase
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + ONE_PTR) : rd_ptr_r;
        bypass_s     = we_s & (waddr_s == rd_ptr_nxt_s);
    end

    // Pool storage, written by the fill sequence or by returned pointers
    always_ff @(posedge clk_i) begin
        if (we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Pointers, count, show-ahead head register and sticky flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_idx_r  <= ZERO_PTR;
            wr_ptr_r    <= ZERO_PTR;
            rd_ptr_r    <= ZERO_PTR;
            head_r      <= ZERO_PTR;
            count_r     <= ZERO_CNT;
            val_r       <= 1'b0;
            init_done_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (ptr_if.srst) begin
            init_idx_r  <= ZERO_PTR;
            wr_ptr_r    <= ZERO_PTR;
            rd_ptr_r    <= ZERO_PTR;
            head_r      <= ZERO_PTR;
            count_r     <= ZERO_CNT;
            val_r       <= 1'b0;
            init_done_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r | ovf_set_s;
            underflow_r <= underflow_r | unf_set_s;
            // registered RAM read of the next head; bypass covers a same-edge write
            head_r      <= bypass_s ? wdata_s : mem_r[rd_ptr_nxt_s];
            if (state_r == ST_INIT) begin
                init_idx_r <= init_idx_r + ONE_PTR;
                if (init_last_s) begin
                    count_r     <= FULL_CNT;
                    val_r       <= 1'b1;
                    init_done_r <= 1'b1;
                end else begin
                    count_r     <= ZERO_CNT;
                    val_r       <= 1'b0;
                    init_done_r <= 1'b0;
                end
            end else begin
                count_r  <= count_nxt_s;
                val_r    <= (count_nxt_s != ZERO_CNT);
                rd_ptr_r <= rd_ptr_nxt_s;
                wr_ptr_r <= push_s ? (wr_ptr_r + ONE_PTR) : wr_ptr_r;
            end
        end
    end

    assign ptr_if.next_empty_ptr     = head_r;
    assign ptr_if.next_empty_ptr_val = val_r;
    assign init_done_o               = init_done_r;
    assign free_cnt_o                = count_r;
    assign overflow_o                = overflow_r;
    assign underflow_o               = underflow_r;

endmodule

// File: tb/tb_empty_ptr_pool.sv
// Scoreboard bench for empty_ptr_pool: a queue-based free-list model predicts
// every handed-out pointer and the status outputs each cycle.
module tb_empty_ptr_pool;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    empty_ptr_storage_if #(.A_WIDTH(AW)) ptr_if ();

    logic          init_done;
    logic [AW:0]   free_cnt;
    logic          ovf, unf;

    empty_ptr_pool #(.A_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ptr_if      (ptr_if),
        .init_done_o (init_done),
        .free_cnt_o  (free_cnt),
        .overflow_o  (ovf),
        .underflow_o (unf)
    );

    // reference model: pool contents as a plain queue
    logic [AW-1:0] m_q [$];
    bit            m_run;
    int            m_init_left;
    bit            m_ovf, m_unf;
    logic [AW-1:0] exp_q [$];
    int            tests = 0;
    int            fails = 0;

    task automatic model_reset();
        m_q.delete();
        m_run       = 1'b0;
        m_init_left = DEPTH;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
    endtask

    // drive one cycle of stimulus, record expected pops, advance the model
    task automatic cycle(input bit ack, input bit add_en, input logic [AW-1:0] p, input bit srst_v);
        bit            pop, push;
        logic [AW-1:0] v;
        ptr_if.next_empty_ptr_rd_ack = ack;
        ptr_if.add_empty_ptr_en      = add_en;
        ptr_if.add_empty_ptr         = p;
        ptr_if.srst                  = srst_v;
        pop = !srst_v && !rst && m_run && ack && (m_q.size() > 0);
        if (pop) exp_q.push_back(m_q[0]);
        @(posedge clk);
        if (rst || srst_v) begin
            model_reset();
        end else if (!m_run) begin
            if (add_en) m_ovf = 1'b1;
            if (ack) m_unf = 1'b1;
            m_init_left--;
            if (m_init_left == 0) begin
                m_run = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    v = i[AW-1:0];
                    m_q.push_back(v);
                end
            end
        end else begin
            if (ack && m_q.size() == 0) m_unf = 1'b1;
            push = add_en && ((m_q.size() < DEPTH) || pop);
            if (add_en && !push) m_ovf = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(p);
        end
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    // monitor: status every cycle, popped pointer whenever a pop is presented
    logic [AW+4:0] got_st, exp_st;
    logic [AW:0]   exp_cnt;
    logic [AW-1:0] exp_ptr;
    int            sz;
    always @(negedge clk) begin
        sz      = m_q.size();
        exp_cnt = m_run ? sz[AW:0] : '0;
        exp_st  = {m_run && (sz > 0), exp_cnt, m_run, m_ovf, m_unf};
        got_st  = {ptr_if.next_empty_ptr_val, free_cnt, init_done, ovf, unf};
        tests++;
        if (got_st !== exp_st) begin
            fails++;
            $display("FAIL status t=%0t got val=%b cnt=%0d done=%b ovf=%b unf=%b, expected val=%b cnt=%0d done=%b ovf=%b unf=%b",
                     $time, got_st[AW+4], got_st[AW+3:3], got_st[2], got_st[1], got_st[0],
                     exp_st[AW+4], exp_st[AW+3:3], exp_st[2], exp_st[1], exp_st[0]);
        end
        if (rst) begin
            tests++;
            if (ptr_if.next_empty_ptr !== '0) begin
                fails++;
                $display("FAIL reset_ptr t=%0t got %0d expected 0", $time, ptr_if.next_empty_ptr);
            end
        end
        if (ptr_if.next_empty_ptr_rd_ack && ptr_if.next_empty_ptr_val && !ptr_if.srst && !rst) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected t=%0t got ptr %0d, expected no pop", $time, ptr_if.next_empty_ptr);
            end else begin
                exp_ptr = exp_q.pop_front();
                if (ptr_if.next_empty_ptr !== exp_ptr) begin
                    fails++;
                    $display("FAIL pop_ptr t=%0t got %0d expected %0d", $time, ptr_if.next_empty_ptr, exp_ptr);
                end
            end
        end
    end

    initial begin
        int            thr;
        bit            a, d;
        logic [AW-1:0] p;
        model_reset();
        ptr_if.srst                  = 1'b0;
        ptr_if.add_empty_ptr         = '0;
        ptr_if.add_empty_ptr_en      = 1'b0;
        ptr_if.next_empty_ptr_rd_ack = 1'b0;
        rst = 1'b1;
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;

        // fill, then drain with back-to-back acks plus one extra (underflow)
        idle(DEPTH + 1);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        // return 7 into an empty pool and take it straight back
        cycle(1'b0, 1'b1, 4'd7, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        idle(2);

        // soft reset clears flags; full-pool overflow, then add with pop
        cycle(1'b0, 1'b0, '0, 1'b1);
        idle(DEPTH + 1);
        cycle(1'b0, 1'b1, 4'd3, 1'b0);
        cycle(1'b1, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        idle(1);

        // random traffic from a clean pool, constrained to stay flag-free
        cycle(1'b0, 1'b0, '0, 1'b1);
        idle(DEPTH + 1);
        for (int i = 0; i < 500; i++) begin
            thr = ((i / 50) % 2 == 0) ? 70 : 30;
            a = ($urandom_range(0, 99) < thr) && (m_q.size() > 0);
            d = ($urandom_range(0, 99) >= thr) && ((m_q.size() < DEPTH) || a);
            p = AW'($urandom);
            cycle(a, d, p, 1'b0);
        end

        // bring count to 5, then soft reset with traffic in the same cycle
        for (int i = 0; i < 40 && m_q.size() > 5; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 40 && m_q.size() < 5; i++) cycle(1'b0, 1'b1, AW'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 4'd9, 1'b1);
        // flags set during INIT, then async reset at fill index 9
        cycle(1'b1, 1'b1, 4'd1, 1'b0);
        idle(8);
        rst = 1'b1;
        model_reset();
        #1;
        cycle(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        idle(DEPTH);
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        idle(2);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_pops got %0d outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
